// File: rtl/seven_seg_scan_ctrl.sv
// Six-digit multiplexed 7-segment scan scheduler: blank lead-in, brightness-sized ON window, frame tick.
// Optional macro SEG_SCAN_DP_BLINK_EN adds blink_mask / BLINK_FRAMES per-digit blinking.
module seven_seg_scan_ctrl #(
    parameter int N_DIGITS     = 6,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int BRIGHT_W     = 4
`ifdef SEG_SCAN_DP_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                disp_en,
    input  logic [5:0]          en_mask,
    input  logic [BRIGHT_W-1:0] brightness,
    input  logic [6:0]          seg0,
    input  logic [6:0]          seg1,
    input  logic [6:0]          seg2,
    input  logic [6:0]          seg3,
    input  logic [6:0]          seg4,
    input  logic [6:0]          seg5,
`ifdef SEG_SCAN_DP_BLINK_EN
    input  logic [5:0]          blink_mask,
`endif
    output logic [6:0]          seg,
    output logic [5:0]          an,
    output logic [2:0]          digit_sel,
    output logic                frame_tick
);

    localparam int CNT_W  = $clog2(DWELL_CYCLES);
    localparam int ACTIVE = DWELL_CYCLES - BLANK_CYCLES;
    localparam int PW     = CNT_W + BRIGHT_W;
    localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACTIVE_C = CNT_W'(ACTIVE);

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_ON    = 2'd1,
        ST_OFF   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   on_len_q, on_len_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         digit_sel_q, digit_sel_d;
    logic               active_q, active_d;
    logic [5:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               frame_tick_q, frame_tick_d;

    logic               scan_ok;
    logic               lit;
    logic [2:0]         low_idx, after_idx, nxt_digit;
    logic               after_found;
    logic [PW-1:0]      bright_prod;
    logic [CNT_W-1:0]   on_len_calc;
    logic [CNT_W:0]     on_end;
    logic [6:0]         seg_sel;

`ifdef SEG_SCAN_DP_BLINK_EN
    localparam int FC_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
    logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic               dark_q, dark_d;
`endif

    assign scan_ok = disp_en && (en_mask != 6'd0);

    // Next digit: lowest enabled index above the pointer, else wrap to the lowest enabled index.
    always_comb begin
        low_idx     = 3'd0;
        after_idx   = 3'd0;
        after_found = 1'b0;
        for (int j = N_DIGITS - 1; j >= 0; j--) begin
            if (en_mask[j]) begin
                low_idx = 3'(j);
                if (j > int'(ptr_q)) begin
                    after_idx   = 3'(j);
                    after_found = 1'b1;
                end
            end
        end
        nxt_digit = after_found ? after_idx : low_idx;
    end

    always_comb begin
        bright_prod = PW'(ACTIVE) * PW'(brightness);
        on_len_calc = (brightness == {BRIGHT_W{1'b1}}) ? ACTIVE_C : CNT_W'(bright_prod >> BRIGHT_W);
        on_end      = {1'b0, BLANK_C} + {1'b0, on_len_q};
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        on_len_d     = on_len_q;
        ptr_d        = ptr_q;
        digit_sel_d  = digit_sel_q;
        active_d     = active_q;
        frame_tick_d = 1'b0;
`ifdef SEG_SCAN_DP_BLINK_EN
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        dark_d        = dark_q;
`endif
        if (!scan_ok) begin
            active_d = 1'b0;
            cnt_d    = '0;
            state_d  = ST_BLANK;
        end else if (!active_q || cnt_q == LAST_C) begin
            active_d     = 1'b1;
            cnt_d        = '0;
            state_d      = ST_BLANK;
            digit_sel_d  = nxt_digit;
            ptr_d        = nxt_digit;
            on_len_d     = on_len_calc;
            frame_tick_d = (nxt_digit == low_idx);
`ifdef SEG_SCAN_DP_BLINK_EN
            // Darkness is decided by the phase before this tick's update.
            dark_d = blink_phase_q && blink_mask[nxt_digit];
            if (nxt_digit == low_idx) begin
                if (frame_cnt_q == FC_LAST) begin
                    frame_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
`endif
        end else begin
            cnt_d = cnt_q + 1'b1;
            case (state_q)
                ST_BLANK: if (cnt_d == BLANK_C) state_d = (on_len_q == '0) ? ST_OFF : ST_ON;
                ST_ON:    if ({1'b0, cnt_d} == on_end) state_d = ST_OFF;
                default:  state_d = ST_OFF;
            endcase
        end
    end

    always_comb begin
        case (digit_sel_d)
            3'd0:    seg_sel = seg0;
            3'd1:    seg_sel = seg1;
            3'd2:    seg_sel = seg2;
            3'd3:    seg_sel = seg3;
            3'd4:    seg_sel = seg4;
            3'd5:    seg_sel = seg5;
            default: seg_sel = 7'h7F;
        endcase
`ifdef SEG_SCAN_DP_BLINK_EN
        lit = (state_d == ST_ON) && !dark_d;
`else
        lit = (state_d == ST_ON);
`endif
        an_d  = 6'h3F;
        seg_d = 7'h7F;
        if (lit) begin
            an_d[digit_sel_d] = 1'b0;
            seg_d             = seg_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            on_len_q     <= '0;
            ptr_q        <= 3'(N_DIGITS - 1);
            digit_sel_q  <= 3'd0;
            active_q     <= 1'b0;
            an_q         <= 6'h3F;
            seg_q        <= 7'h7F;
            frame_tick_q <= 1'b0;
`ifdef SEG_SCAN_DP_BLINK_EN
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            dark_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            on_len_q     <= on_len_d;
            ptr_q        <= ptr_d;
            digit_sel_q  <= digit_sel_d;
            active_q     <= active_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
`ifdef SEG_SCAN_DP_BLINK_EN
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            dark_q        <= dark_d;
`endif
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign digit_sel  = digit_sel_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with DWELL=8, BLANK=2, BRIGHT_W=2 (ON window = 6 at full brightness).
module tb_seven_seg_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       disp_en;
    logic [5:0] en_mask;
    logic [1:0] brightness;
    logic [6:0] seg_pat [6];
    logic [6:0] seg;
    logic [5:0] an;
    logic [2:0] digit_sel;
    logic       frame_tick;
`ifdef SEG_SCAN_DP_BLINK_EN
    logic [5:0] blink_mask;
`endif

    int checks = 0;
    int errors = 0;

    seven_seg_scan_ctrl #(
        .N_DIGITS(6), .DWELL_CYCLES(8), .BLANK_CYCLES(2), .BRIGHT_W(2)
`ifdef SEG_SCAN_DP_BLINK_EN
        , .BLINK_FRAMES(2)
`endif
    ) dut (
        .clk(clk), .rst(rst), .disp_en(disp_en), .en_mask(en_mask), .brightness(brightness),
        .seg0(seg_pat[0]), .seg1(seg_pat[1]), .seg2(seg_pat[2]),
        .seg3(seg_pat[3]), .seg4(seg_pat[4]), .seg5(seg_pat[5]),
`ifdef SEG_SCAN_DP_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg(seg), .an(an), .digit_sel(digit_sel), .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_blank(input string tag, input int dsel);
        check({tag, " an"}, 32'(an), 32'h3F);
        check({tag, " seg"}, 32'(seg), 32'h7F);
        check({tag, " dsel"}, 32'(digit_sel), 32'(dsel));
        check({tag, " ft"}, 32'(frame_tick), 32'd0);
    endtask

    // One full slot of digit d with an ON window of n_on cycles; optional mask change at cycle 3.
    task automatic run_slot(input int d, input int n_on, input bit ft, input bit chg, input logic [5:0] new_mask);
        logic [5:0] one_hot;
        logic [5:0] exp_an;
        logic [6:0] exp_seg;
        bit         lit;
        for (int c = 0; c < 8; c++) begin
            step();
            one_hot = 6'd1 << d;
            lit     = (c >= 2) && (c < 2 + n_on);
            exp_an  = lit ? ~one_hot : 6'h3F;
            exp_seg = lit ? seg_pat[d] : 7'h7F;
            check($sformatf("an d%0d c%0d", d, c), 32'(an), 32'(exp_an));
            check($sformatf("seg d%0d c%0d", d, c), 32'(seg), 32'(exp_seg));
            check($sformatf("dsel d%0d c%0d", d, c), 32'(digit_sel), 32'(d));
            check($sformatf("ft d%0d c%0d", d, c), 32'(frame_tick), 32'(ft && c == 0));
            if (chg && c == 3) en_mask = new_mask;
        end
    endtask

    initial begin
        seg_pat[0] = 7'h40; seg_pat[1] = 7'h79; seg_pat[2] = 7'h24;
        seg_pat[3] = 7'h30; seg_pat[4] = 7'h19; seg_pat[5] = 7'h12;
        rst = 1'b1; disp_en = 1'b1; en_mask = 6'h3F; brightness = 2'd3;
`ifdef SEG_SCAN_DP_BLINK_EN
        blink_mask = 6'd0;
`endif
        step(); step(); step();
        check_blank("reset", 0);

        // Full brightness, all digits: 0..5 then 0 again with a frame tick each 48 cycles.
        rst = 1'b0;
        for (int d = 0; d < 6; d++) run_slot(d, 6, d == 0, 1'b0, 6'd0);
        run_slot(0, 6, 1'b1, 1'b0, 6'd0);

        brightness = 2'd2; run_slot(1, 3, 1'b0, 1'b0, 6'd0);
        brightness = 2'd0; run_slot(2, 0, 1'b0, 1'b0, 6'd0);
        brightness = 2'd1; run_slot(3, 1, 1'b0, 1'b0, 6'd0);

        // Sparse mask; dropping bit 5 mid-slot leaves digit 2 alone, ticking every slot.
        brightness = 2'd3; en_mask = 6'b100100;
        run_slot(5, 6, 1'b0, 1'b0, 6'd0);
        run_slot(2, 6, 1'b1, 1'b0, 6'd0);
        run_slot(5, 6, 1'b0, 1'b0, 6'd0);
        run_slot(2, 6, 1'b1, 1'b1, 6'b000100);
        run_slot(2, 6, 1'b1, 1'b0, 6'd0);
        run_slot(2, 6, 1'b1, 1'b0, 6'd0);

        // disp_en dropped mid-ON of digit 3, with a live segment change just before.
        en_mask = 6'h3F;
        step(); check("de dsel", 32'(digit_sel), 32'd3); check("de ft", 32'(frame_tick), 32'd0);
        step(); check("de blank an", 32'(an), 32'h3F);
        step(); check("de on an", 32'(an), 32'h37); check("de on seg", 32'(seg), 32'h30);
        seg_pat[3] = 7'h2A;
        step(); check("de live an", 32'(an), 32'h37); check("de live seg", 32'(seg), 32'h2A);
        disp_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); check_blank($sformatf("de off %0d", i), 3);
        end
        disp_en = 1'b1;
        run_slot(4, 6, 1'b0, 1'b0, 6'd0);

        // Empty mask for 20 cycles, then resume on the digit after the pointer.
        en_mask = 6'd0;
        for (int i = 0; i < 20; i++) begin
            step(); check_blank($sformatf("mask0 %0d", i), 4);
        end
        en_mask = 6'h3F;
        step(); check("res dsel", 32'(digit_sel), 32'd5); check("res ft", 32'(frame_tick), 32'd0);
        step(); check("res blank an", 32'(an), 32'h3F);
        step(); check("res on an", 32'(an), 32'h1F); check("res on seg", 32'(seg), 32'h12);

        // Reset mid-ON wins over everything; first slot goes to the lowest enabled digit.
        rst = 1'b1; disp_en = 1'b1;
        step(); check_blank("rst mid", 0);
        step(); check_blank("rst hold", 0);
        en_mask = 6'b001010; rst = 1'b0;
        run_slot(1, 6, 1'b1, 1'b0, 6'd0);
        run_slot(3, 6, 1'b0, 1'b0, 6'd0);
        run_slot(1, 6, 1'b1, 1'b0, 6'd0);

`ifdef SEG_SCAN_DP_BLINK_EN
        // Digit 0 dark in frames 2-3 only.
        rst = 1'b1; step();
        rst = 1'b0; en_mask = 6'h3F; blink_mask = 6'b000001;
        for (int f = 0; f < 6; f++)
            for (int d = 0; d < 6; d++)
                run_slot(d, (d == 0 && (f == 2 || f == 3)) ? 0 : 6, d == 0, 1'b0, 6'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
